nibble_distributor: RTL and testbench
=====================================

NIBBLE_DISTRIBUTOR -- requirements
Module: nibble_distributor

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port RST, input, 1 bit: synchronous reset, active-high.
REQ-003 SHALL have port I, input, 4 bits: input nibble.
REQ-004 SHALL have port VI, input, 1 bit: I valid.
REQ-005 SHALL have port RI, output, 1 bit: ready for input; a transfer occurs on an edge where VI=1 and RI=1.
REQ-006 SHALL have port HAB, input, 1 bit: enable; 0 blocks new transfers.
REQ-007 SHALL have port COD, input, 1 bit: destination select when MODE=0 (0 selects channel 0, 1 selects channel 1).
REQ-008 SHALL have port MODE, input, 1 bit: 0 routes by COD; 1 routes round-robin by internal pointer PTR.
REQ-009 SHALL have ports O0 and O1, output, 4 bits each: channel data.
REQ-010 SHALL have ports V0 and V1, output, 1 bit each: channel data valid.
REQ-011 SHALL have ports A0 and A1, input, 1 bit each: consumer acknowledge; Ax=1 with Vx=1 at an edge consumes channel x.
REQ-012 SHALL have ports CNT0 and CNT1, output, 4 bits each: delivered-nibble counts per channel.

Function
REQ-013 SHALL implement one 1-entry holding register per channel, each with two states: EMPTY (Vx=0) and FULL (Vx=1).
REQ-014 SHALL compute target channel T as MODE ? PTR : COD.
REQ-015 SHALL drive RI combinationally as HAB & !RST & (V[T]=0 | A[T]=1).
REQ-016 SHALL, on a transfer, load I into channel T and set V[T]=1 at that edge; O[T] and V[T] SHALL be visible in the cycle after the edge (1-cycle latency).
REQ-017 SHALL hold Ox stable while Vx=1 until consumed; I, COD and MODE changes SHALL NOT disturb a FULL channel.
REQ-018 SHALL drive Ox=4'b1111 whenever Vx=0.
REQ-019 SHALL, on consumption (Vx=1 and Ax=1) without a transfer into x, return x to EMPTY at that edge.
REQ-020 SHALL, on simultaneous consumption of x and transfer into x, load the new nibble and keep Vx=1; no bubble and no loss.
REQ-021 SHALL ignore Ax when Vx=0: no state change and no count.
REQ-022 SHALL handle both channels independently in the same cycle: a transfer into one channel plus consumption of the other.
REQ-023 SHALL toggle PTR on every transfer made while MODE=1; PTR SHALL hold while MODE=0 and SHALL NOT reset on MODE changes.
REQ-024 SHALL, with MODE=1 and channel PTR FULL and unacknowledged, hold RI=0 and SHALL NOT skip to the other channel.
REQ-025 SHALL, with HAB=0, hold RI=0 and accept no transfers; FULL channels SHALL retain data and consumption SHALL continue normally.
REQ-026 SHALL increment CNTx by 1 on each consumption of channel x, mod 16 (4'b1111 wraps to 4'b0000 with no flag).

Reset
REQ-027 SHALL, on any edge with RST=1, set V0=V1=0, O0=O1=4'b1111, PTR=0 and CNT0=CNT1=0, regardless of VI, Ax or HAB.
REQ-028 SHALL hold RI=0 while RST=1.
REQ-029 SHALL, on reset mid-operation, discard held nibbles; any ack seen in the reset cycle SHALL NOT count.
REQ-030 SHALL accept a transfer on the first edge after RST falls, provided HAB=1.

Verification
REQ-031 SHALL cover COD steering: HAB=1, MODE=0, COD=1, I=4'hA, VI=1 for one edge -> V1=1, O1=4'hA, V0=0, O0=4'hF; then A1=1 for one edge -> V1=0, O1=4'hF, CNT1=1.
REQ-032 SHALL cover round-robin: MODE=1, send 4'h3, 4'h5, 4'h7 with no acks -> O0=3, O1=5; RI=0 while offering 7; A0 pulse -> 7 loads into channel 0 on the next edge.
REQ-033 SHALL cover back-to-back throughput: MODE=0, COD=0, V0=1 holding 4'h1, A0=1 and VI=1 with I=4'h2 on the same edge -> V0 stays 1, O0=4'h2, CNT0 increments.
REQ-034 SHALL cover disable: both channels FULL, HAB=0, VI=1 -> RI=0; A0 pulse -> V0=0; with no new transfer, V1 and O1 unchanged.
REQ-035 SHALL cover counter wrap: 16 transfers and acks on channel 1 -> CNT1 goes 4'hF then 4'h0.
REQ-036 SHALL cover reset mid-operation: V0=1, PTR=1, CNT0=5, assert RST with A0=1 -> next cycle V0=0, O0=4'hF, PTR=0, CNT0=0, RI=0.

Source files
------------

// File: rtl/nibble_distributor.sv
// Two-channel nibble distributor: each accepted nibble is steered to one of two
// single-entry holding registers, either by COD or round-robin, and counted when consumed.
module nibble_distributor (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] I,
    input  logic       VI,
    output logic       RI,
    input  logic       HAB,
    input  logic       COD,
    input  logic       MODE,
    output logic [3:0] O0,
    output logic [3:0] O1,
    output logic       V0,
    output logic       V1,
    input  logic       A0,
    input  logic       A1,
    output logic [3:0] CNT0,
    output logic [3:0] CNT1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chanState_t;

    chanState_t state0, state1, stateNext0, stateNext1;
    logic [3:0] data0, data1, dataNext0, dataNext1;
    logic [3:0] cnt0, cnt1;
    logic       ptr;
    logic       target;
    logic       targetFull;
    logic       targetAck;
    logic       xfer;
    logic       cons0, cons1;

    // The destination is chosen before the handshake so RI reflects only that channel;
    // a full round-robin target stalls the input rather than skipping ahead.
    always_comb begin
        target     = MODE ? ptr : COD;
        targetFull = target ? (state1 == FULL) : (state0 == FULL);
        targetAck  = target ? A1 : A0;
        RI         = HAB & ~RST & (~targetFull | targetAck);
        xfer       = VI & RI;
        cons0      = (state0 == FULL) & A0;
        cons1      = (state1 == FULL) & A1;
    end

    // A load into a channel wins over its consumption, so a simultaneous ack and
    // transfer leaves the channel full with the new nibble.
    always_comb begin
        stateNext0 = state0;
        stateNext1 = state1;
        dataNext0  = data0;
        dataNext1  = data1;
        if (cons0) begin
            stateNext0 = EMPTY;
        end
        if (cons1) begin
            stateNext1 = EMPTY;
        end
        if (xfer && !target) begin
            stateNext0 = FULL;
            dataNext0  = I;
        end
        if (xfer && target) begin
            stateNext1 = FULL;
            dataNext1  = I;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state0 <= EMPTY;
            state1 <= EMPTY;
            data0  <= 4'hF;
            data1  <= 4'hF;
            ptr    <= 1'b0;
            cnt0   <= 4'd0;
            cnt1   <= 4'd0;
        end else begin
            state0 <= stateNext0;
            state1 <= stateNext1;
            data0  <= dataNext0;
            data1  <= dataNext1;
            if (xfer && MODE) begin
                ptr <= ~ptr;
            end
            if (cons0) begin
                cnt0 <= cnt0 + 4'd1;
            end
            if (cons1) begin
                cnt1 <= cnt1 + 4'd1;
            end
        end
    end

    always_comb begin
        V0   = (state0 == FULL);
        V1   = (state1 == FULL);
        O0   = V0 ? data0 : 4'hF;
        O1   = V1 ? data1 : 4'hF;
        CNT0 = cnt0;
        CNT1 = cnt1;
    end

endmodule

// File: tb/tb_nibble_distributor.sv
// Directed bench for nibble_distributor: hand-computed expectations for steering,
// round-robin, back-to-back loads, disable, counter wrap and reset behaviour.
module tb_nibble_distributor;

    logic       CLK;
    logic       RST;
    logic [3:0] I;
    logic       VI;
    logic       RI;
    logic       HAB;
    logic       COD;
    logic       MODE;
    logic [3:0] O0, O1;
    logic       V0, V1;
    logic       A0, A1;
    logic [3:0] CNT0, CNT1;

    int checks = 0;
    int errors = 0;

    nibble_distributor dut (
        .CLK (CLK),
        .RST (RST),
        .I   (I),
        .VI  (VI),
        .RI  (RI),
        .HAB (HAB),
        .COD (COD),
        .MODE(MODE),
        .O0  (O0),
        .O1  (O1),
        .V0  (V0),
        .V1  (V1),
        .A0  (A0),
        .A1  (A1),
        .CNT0(CNT0),
        .CNT1(CNT1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and settle before checks.
    task automatic applyStimulus(input logic rst, input logic hab, input logic mode, input logic cod,
                                 input logic vi, input logic [3:0] din, input logic a0, input logic a1);
        RST  = rst;
        HAB  = hab;
        MODE = mode;
        COD  = cod;
        VI   = vi;
        I    = din;
        A0   = a0;
        A1   = a1;
        #1;
    endtask

    task automatic clockCycle();
        @(posedge CLK);
        #1;
    endtask

    logic [3:0] expCnt1;

    initial begin
        applyStimulus(1, 1, 0, 0, 1, 4'h5, 1, 1);
        clockCycle();
        clockCycle();
        checkOutput("rst_V0", V0, 0);
        checkOutput("rst_V1", V1, 0);
        checkOutput("rst_O0", O0, 4'hF);
        checkOutput("rst_O1", O1, 4'hF);
        checkOutput("rst_CNT0", CNT0, 0);
        checkOutput("rst_CNT1", CNT1, 0);
        checkOutput("rst_RI", RI, 0);

        // COD steering, accepted on the first edge after reset falls
        applyStimulus(0, 1, 0, 1, 1, 4'hA, 0, 0);
        checkOutput("cod_RI", RI, 1);
        clockCycle();
        applyStimulus(0, 1, 0, 1, 0, 4'h0, 0, 0);
        checkOutput("cod_V1", V1, 1);
        checkOutput("cod_O1", O1, 4'hA);
        checkOutput("cod_V0", V0, 0);
        checkOutput("cod_O0", O0, 4'hF);
        applyStimulus(0, 1, 0, 1, 0, 4'h0, 1, 1);
        clockCycle();
        applyStimulus(0, 1, 0, 1, 0, 4'h0, 0, 0);
        checkOutput("ack_V1", V1, 0);
        checkOutput("ack_O1", O1, 4'hF);
        checkOutput("ack_CNT1", CNT1, 1);
        checkOutput("ackEmpty_CNT0", CNT0, 0);

        // Round-robin: 3 -> ch0, 5 -> ch1, 7 stalls on full ch0
        applyStimulus(0, 1, 1, 0, 1, 4'h3, 0, 0);
        clockCycle();
        applyStimulus(0, 1, 1, 0, 1, 4'h5, 0, 0);
        clockCycle();
        applyStimulus(0, 1, 1, 0, 1, 4'h7, 0, 0);
        checkOutput("rr_RIstall", RI, 0);
        clockCycle();
        checkOutput("rr_O0", O0, 4'h3);
        checkOutput("rr_O1", O1, 4'h5);
        checkOutput("rr_RIstill", RI, 0);
        applyStimulus(0, 1, 1, 0, 1, 4'h7, 1, 0);
        checkOutput("rr_RIack", RI, 1);
        clockCycle();
        applyStimulus(0, 1, 1, 0, 0, 4'h0, 0, 0);
        checkOutput("rr_O0_7", O0, 4'h7);
        checkOutput("rr_V0", V0, 1);
        checkOutput("rr_O1held", O1, 4'h5);
        checkOutput("rr_CNT0", CNT0, 1);

        // Disable with both channels full; consumption still proceeds
        applyStimulus(0, 0, 1, 0, 1, 4'hE, 0, 0);
        checkOutput("dis_RI", RI, 0);
        applyStimulus(0, 0, 1, 0, 1, 4'hE, 1, 0);
        checkOutput("dis_RIack", RI, 0);
        clockCycle();
        applyStimulus(0, 0, 1, 0, 1, 4'hE, 0, 0);
        checkOutput("dis_V0", V0, 0);
        checkOutput("dis_V1", V1, 1);
        checkOutput("dis_O1", O1, 4'h5);
        checkOutput("dis_CNT0", CNT0, 2);
        clockCycle();
        checkOutput("dis_V0hold", V0, 0);
        applyStimulus(0, 1, 1, 0, 0, 4'h0, 0, 1);
        clockCycle();
        checkOutput("dis_CNT1", CNT1, 2);

        // Back-to-back reload of channel 0 in the same edge as its ack
        applyStimulus(0, 1, 0, 0, 1, 4'h1, 0, 0);
        clockCycle();
        applyStimulus(0, 1, 0, 0, 1, 4'h2, 1, 0);
        checkOutput("b2b_RI", RI, 1);
        clockCycle();
        applyStimulus(0, 1, 0, 0, 0, 4'h0, 0, 0);
        checkOutput("b2b_V0", V0, 1);
        checkOutput("b2b_O0", O0, 4'h2);
        checkOutput("b2b_CNT0", CNT0, 3);

        // PTR held at 1 through MODE=0 traffic, so this goes to channel 1
        applyStimulus(0, 1, 1, 0, 1, 4'h9, 0, 0);
        checkOutput("ptr_RI", RI, 1);
        clockCycle();
        applyStimulus(0, 1, 1, 0, 0, 4'h0, 0, 0);
        checkOutput("ptr_O1", O1, 4'h9);
        checkOutput("ptr_O0", O0, 4'h2);
        applyStimulus(0, 1, 0, 0, 0, 4'h0, 1, 1);
        clockCycle();
        checkOutput("clr_CNT0", CNT0, 4);
        checkOutput("clr_CNT1", CNT1, 3);

        // Independent channels: load channel 0 while consuming channel 1
        applyStimulus(0, 1, 0, 1, 1, 4'h4, 0, 0);
        clockCycle();
        applyStimulus(0, 1, 0, 0, 1, 4'h6, 0, 1);
        clockCycle();
        applyStimulus(0, 1, 0, 0, 0, 4'h0, 0, 0);
        checkOutput("ind_V0", V0, 1);
        checkOutput("ind_O0", O0, 4'h6);
        checkOutput("ind_V1", V1, 0);
        checkOutput("ind_CNT1", CNT1, 4);
        applyStimulus(0, 1, 0, 0, 0, 4'h0, 1, 0);
        clockCycle();
        checkOutput("ind_CNT0", CNT0, 5);

        // CNT1 runs 4 -> 15 -> 0 -> 4 over sixteen deliveries
        expCnt1 = 4'd4;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, 1, 0, 1, 1, 4'(k), 0, 0);
            clockCycle();
            applyStimulus(0, 1, 0, 1, 0, 4'h0, 0, 1);
            clockCycle();
            expCnt1 = expCnt1 + 4'd1;
            checkOutput($sformatf("wrap_CNT1_%0d", k), CNT1, expCnt1);
        end
        applyStimulus(0, 1, 0, 1, 0, 4'h0, 0, 0);

        // Reset mid-operation with V0=1, PTR=1, CNT0=5 and an ack pending
        applyStimulus(0, 1, 1, 0, 1, 4'h8, 0, 0);
        clockCycle();
        applyStimulus(1, 1, 1, 0, 1, 4'h8, 1, 0);
        checkOutput("mrst_RIduring", RI, 0);
        clockCycle();
        applyStimulus(1, 1, 1, 0, 0, 4'h0, 0, 0);
        checkOutput("mrst_V0", V0, 0);
        checkOutput("mrst_O0", O0, 4'hF);
        checkOutput("mrst_CNT0", CNT0, 0);
        checkOutput("mrst_RI", RI, 0);
        applyStimulus(0, 1, 1, 0, 1, 4'hC, 0, 0);
        checkOutput("mrst_RIafter", RI, 1);
        clockCycle();
        applyStimulus(0, 1, 1, 0, 0, 4'h0, 0, 0);
        checkOutput("mrst_ptr_V0", V0, 1);
        checkOutput("mrst_ptr_O0", O0, 4'hC);
        checkOutput("mrst_ptr_V1", V1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
